// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT post-processing blocks.
package fft_pkg;

  localparam int DW = 14;
  localparam int N  = 1024;
  localparam int IW = $clog2(N);
  localparam int MW = 2 * DW;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } peak_state_e;

endpackage

// File: rtl/fft_mag_peak_if.sv
// Bin stream in, magnitude stream and per-frame peak report out.
interface fft_mag_peak_if #(
  parameter int DW = fft_pkg::DW,
  parameter int N  = fft_pkg::N
);

  localparam int IW = $clog2(N);
  localparam int MW = 2 * DW;

  logic                 in_valid;
  logic                 in_last;
  logic signed [DW-1:0] data_re;
  logic signed [DW-1:0] data_im;

  logic                 mag_valid;
  logic [IW-1:0]        mag_idx;
  logic [MW-1:0]        mag_out;
  logic                 mag_last;

  logic                 peak_valid;
  logic [IW-1:0]        peak_idx;
  logic [MW-1:0]        peak_mag;
  logic                 frame_err;

  modport master (
    output in_valid, in_last, data_re, data_im,
    input  mag_valid, mag_idx, mag_out, mag_last,
    input  peak_valid, peak_idx, peak_mag, frame_err
  );

  modport slave (
    input  in_valid, in_last, data_re, data_im,
    output mag_valid, mag_idx, mag_out, mag_last,
    output peak_valid, peak_idx, peak_mag, frame_err
  );

endinterface

// File: rtl/cplx_mag_sq.sv
// Two-stage |z|^2 pipeline: squares registered at p1, sum registered at p2.
// Side-band bits travel with the sample untouched.
module cplx_mag_sq #(
  parameter int DW  = fft_pkg::DW,
  parameter int SBW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_p0,
  input  logic signed [DW-1:0] re_p0,
  input  logic signed [DW-1:0] im_p0,
  input  logic [SBW-1:0]       sb_p0,
  output logic                 vld_p2,
  output logic [2*DW-1:0]      mag_p2,
  output logic [SBW-1:0]       sb_p2
);

  localparam int PW  = 2 * DW;
  localparam int SQW = 2 * DW - 1;

  // The largest square is (-2^(DW-1))^2 = 2^(2DW-2), so SQW unsigned bits suffice.
  function automatic logic [SQW-1:0] square_u(input logic signed [DW-1:0] x);
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'(x);
    return SQW'(unsigned'(p));
  endfunction

  logic               vld_p1;
  logic [SQW-1:0]     sq_re_p1;
  logic [SQW-1:0]     sq_im_p1;
  logic [SBW-1:0]     sb_p1;

  // ---- stage p0 -> p1: squares ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sq_re_p1 <= square_u(re_p0);
      sq_im_p1 <= square_u(im_p0);
      sb_p1    <= sb_p0;
    end
  end

  // ---- stage p1 -> p2: sum (max 2^(2DW-1), fits in 2DW bits) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      mag_p2 <= '0;
      sb_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mag_p2 <= PW'(sq_re_p1) + PW'(sq_im_p1);
        sb_p2  <= sb_p1;
      end
    end
  end

endmodule

// File: rtl/fft_mag_peak.sv
// Streams |bin|^2 for each FFT bin and reports the per-frame peak bin,
// flagging frames whose length disagrees with N.
module fft_mag_peak #(
  parameter int DW      = fft_pkg::DW,
  parameter int N       = fft_pkg::N,
  parameter bit SKIP_DC = 1'b0
) (
  input  logic           sclk,
  input  logic           s_rst_n,
  fft_mag_peak_if.slave  bus
);

  import fft_pkg::*;

  localparam int IW  = $clog2(N);
  localparam int MW  = 2 * DW;
  localparam int SBW = IW + 2;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] FIRST_IDX = SKIP_DC ? IW'(1) : '0;

  logic [IW-1:0] cnt;
  logic          at_end;
  logic          close_p0;
  logic          err_p0;

  // A frame closes on in_last or when the counter reaches N-1; exactly one
  // of the two without the other is a length error.
  assign at_end   = (cnt == LAST_IDX);
  assign close_p0 = bus.in_last | at_end;
  assign err_p0   = bus.in_last ^ at_end;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)          cnt <= '0;
    else if (bus.in_valid) cnt <= close_p0 ? '0 : cnt + 1'b1;
  end

  logic          vld_p2;
  logic [MW-1:0] mag_p2;
  logic [IW-1:0] idx_p2;
  logic          last_p2;
  logic          err_p2;

  cplx_mag_sq #(
    .DW  (DW),
    .SBW (SBW)
  ) u_mag (
    .clk    (sclk),
    .rst_n  (s_rst_n),
    .vld_p0 (bus.in_valid),
    .re_p0  (bus.data_re),
    .im_p0  (bus.data_im),
    .sb_p0  ({err_p0, close_p0, cnt}),
    .vld_p2 (vld_p2),
    .mag_p2 (mag_p2),
    .sb_p2  ({err_p2, last_p2, idx_p2})
  );

  assign bus.mag_valid = vld_p2;
  assign bus.mag_idx   = idx_p2;
  assign bus.mag_out   = mag_p2;
  assign bus.mag_last  = last_p2;

  peak_state_e   state;
  logic [MW-1:0] run_max;
  logic [IW-1:0] run_idx;
  logic          eligible;
  logic          take;
  logic [MW-1:0] cand_mag;
  logic [IW-1:0] cand_idx;

  // IDLE loads the first eligible bin unconditionally; TRACK needs strictly
  // greater so ties keep the lowest index.
  assign eligible = vld_p2 & ~(SKIP_DC & (idx_p2 == '0));
  assign take     = eligible & ((state == IDLE) | (mag_p2 > run_max));
  assign cand_mag = take ? mag_p2 : run_max;
  assign cand_idx = take ? idx_p2 : run_idx;

  logic          pk_valid;
  logic [IW-1:0] pk_idx;
  logic [MW-1:0] pk_mag;
  logic          pk_err;

  // ---- stage p2 -> p3: peak tracker / frame close ----
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      run_max  <= '0;
      run_idx  <= FIRST_IDX;
      pk_valid <= 1'b0;
      pk_idx   <= '0;
      pk_mag   <= '0;
      pk_err   <= 1'b0;
    end else begin
      pk_valid <= 1'b0;
      pk_err   <= 1'b0;
      if (vld_p2 && last_p2) begin
        pk_valid <= 1'b1;
        pk_idx   <= cand_idx;
        pk_mag   <= cand_mag;
        pk_err   <= err_p2;
        state    <= IDLE;
        run_max  <= '0;
        run_idx  <= FIRST_IDX;
      end else if (take) begin
        run_max  <= mag_p2;
        run_idx  <= idx_p2;
        state    <= TRACK;
      end
    end
  end

  assign bus.peak_valid = pk_valid;
  assign bus.peak_idx   = pk_idx;
  assign bus.peak_mag   = pk_mag;
  assign bus.frame_err  = pk_err;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Bench for fft_mag_peak: two instances (SKIP_DC=0/1) on one shared stream,
// checked every cycle against a frame-level reference model.
module tb_fft_mag_peak;

  localparam int DW = 14;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MW = 28;

  logic sclk = 1'b0;
  logic s_rst_n;
  always #5 sclk = ~sclk;

  logic                 in_valid;
  logic                 in_last;
  logic signed [DW-1:0] data_re;
  logic signed [DW-1:0] data_im;

  fft_mag_peak_if #(.DW(DW), .N(N)) bus0 ();
  fft_mag_peak_if #(.DW(DW), .N(N)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_last  = in_last;
  assign bus0.data_re  = data_re;
  assign bus0.data_im  = data_im;
  assign bus1.in_valid = in_valid;
  assign bus1.in_last  = in_last;
  assign bus1.data_re  = data_re;
  assign bus1.data_im  = data_im;

  fft_mag_peak #(.DW(DW), .N(N), .SKIP_DC(1'b0)) u_dut0 (
    .sclk (sclk), .s_rst_n (s_rst_n), .bus (bus0.slave));
  fft_mag_peak #(.DW(DW), .N(N), .SKIP_DC(1'b1)) u_dut1 (
    .sclk (sclk), .s_rst_n (s_rst_n), .bus (bus1.slave));

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  typedef struct {
    bit     mv;
    longint mag;
    int     midx;
    bit     mlast;
    bit     pv;
    bit     err;
    int     pidx0;
    int     pidx1;
    longint pmag0;
    longint pmag1;
  } exp_t;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    bit                   last;
    longint               mag;
  } vec_t;

  exp_t   ex [int];
  longint held_mag [2];
  int     held_idx [2];
  int     mcnt = 0;
  longint fq_mag [$];
  int     fq_idx [$];
  vec_t   tbl [11];

  function automatic exp_t get_ex(int k);
    exp_t e;
    e = '{default: 0};
    if (ex.exists(k)) e = ex[k];
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Largest eligible magnitude of the buffered frame, lowest index on ties.
  function automatic void frame_peak(input bit skip, output int bi, output longint bm);
    bi = skip ? 1 : 0;
    bm = -1;
    foreach (fq_mag[j]) begin
      if (!(skip && fq_idx[j] == 0) && fq_mag[j] > bm) begin
        bm = fq_mag[j];
        bi = fq_idx[j];
      end
    end
    if (bm < 0) bm = 0;
  endfunction

  task automatic model_in(bit last, longint m);
    exp_t e;
    bit at_end, close;
    at_end = (mcnt == N - 1);
    close  = last || at_end;
    e = get_ex(cyc + 2);
    e.mv = 1; e.mag = m; e.midx = mcnt; e.mlast = close;
    ex[cyc + 2] = e;
    fq_mag.push_back(m);
    fq_idx.push_back(mcnt);
    if (close) begin
      e = get_ex(cyc + 3);
      e.pv  = 1;
      e.err = (last != at_end);
      frame_peak(1'b0, e.pidx0, e.pmag0);
      frame_peak(1'b1, e.pidx1, e.pmag1);
      ex[cyc + 3] = e;
      fq_mag.delete();
      fq_idx.delete();
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic check_dut(int d, logic mv, logic [MW-1:0] mo, logic [IW-1:0] mi, logic ml,
                           logic pv, logic [IW-1:0] pi, logic [MW-1:0] pm, logic fe);
    exp_t e;
    e = get_ex(cyc);
    chk($sformatf("d%0d mag_valid", d), 64'(mv), 64'(e.mv));
    if (e.mv) begin
      chk($sformatf("d%0d mag_out", d), 64'(mo), 64'(e.mag));
      chk($sformatf("d%0d mag_idx", d), 64'(mi), 64'(e.midx));
      chk($sformatf("d%0d mag_last", d), 64'(ml), 64'(e.mlast));
    end
    chk($sformatf("d%0d peak_valid", d), 64'(pv), 64'(e.pv));
    if (e.pv) begin
      held_idx[d] = (d == 0) ? e.pidx0 : e.pidx1;
      held_mag[d] = (d == 0) ? e.pmag0 : e.pmag1;
    end
    chk($sformatf("d%0d peak_idx", d), 64'(pi), 64'(held_idx[d]));
    chk($sformatf("d%0d peak_mag", d), 64'(pm), 64'(held_mag[d]));
    chk($sformatf("d%0d frame_err", d), 64'(fe), 64'(e.pv && e.err));
  endtask

  task automatic check_zero(int d, logic mv, logic [MW-1:0] mo, logic [IW-1:0] mi, logic ml,
                            logic pv, logic [IW-1:0] pi, logic [MW-1:0] pm, logic fe);
    chk($sformatf("d%0d rst mag_valid", d), 64'(mv), 64'd0);
    chk($sformatf("d%0d rst mag_out", d), 64'(mo), 64'd0);
    chk($sformatf("d%0d rst mag_idx", d), 64'(mi), 64'd0);
    chk($sformatf("d%0d rst mag_last", d), 64'(ml), 64'd0);
    chk($sformatf("d%0d rst peak_valid", d), 64'(pv), 64'd0);
    chk($sformatf("d%0d rst peak_idx", d), 64'(pi), 64'd0);
    chk($sformatf("d%0d rst peak_mag", d), 64'(pm), 64'd0);
    chk($sformatf("d%0d rst frame_err", d), 64'(fe), 64'd0);
  endtask

  task automatic check_cycle();
    check_dut(0, bus0.mag_valid, bus0.mag_out, bus0.mag_idx, bus0.mag_last,
              bus0.peak_valid, bus0.peak_idx, bus0.peak_mag, bus0.frame_err);
    check_dut(1, bus1.mag_valid, bus1.mag_out, bus1.mag_idx, bus1.mag_last,
              bus1.peak_valid, bus1.peak_idx, bus1.peak_mag, bus1.frame_err);
  endtask

  task automatic check_all_zero();
    check_zero(0, bus0.mag_valid, bus0.mag_out, bus0.mag_idx, bus0.mag_last,
               bus0.peak_valid, bus0.peak_idx, bus0.peak_mag, bus0.frame_err);
    check_zero(1, bus1.mag_valid, bus1.mag_out, bus1.mag_idx, bus1.mag_last,
               bus1.peak_valid, bus1.peak_idx, bus1.peak_mag, bus1.frame_err);
  endtask

  task automatic model_reset();
    ex.delete();
    fq_mag.delete();
    fq_idx.delete();
    mcnt = 0;
    held_mag[0] = 0; held_mag[1] = 0;
    held_idx[0] = 0; held_idx[1] = 0;
  endtask

  task automatic step(bit v, bit l, logic signed [DW-1:0] r, logic signed [DW-1:0] i, longint m);
    in_valid = v;
    in_last  = v && l;
    data_re  = r;
    data_im  = i;
    if (v) model_in(l, m);
    @(posedge sclk);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 0);
  endtask

  task automatic rnd_bin(bit l, int lim);
    logic signed [DW-1:0] r, i;
    if (lim > 0) begin
      r = DW'($urandom_range(0, lim));
      i = DW'($urandom_range(0, lim));
    end else begin
      r = DW'($urandom());
      i = DW'($urandom());
    end
    step(1'b1, l, r, i, longint'(r) * longint'(r) + longint'(i) * longint'(i));
  endtask

  task automatic async_reset();
    #2;
    s_rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(2);
    s_rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{DW'(3),     DW'(-4),    1'b0, 64'd25};
    tbl[1]  = '{DW'(-8192), DW'(-8192), 1'b0, 64'd134217728};
    tbl[2]  = '{DW'(8191),  DW'(-8192), 1'b1, 64'd134201345};
    tbl[3]  = '{DW'(0), DW'(0), 1'b0, 64'd0};
    tbl[4]  = '{DW'(5), DW'(0), 1'b0, 64'd25};
    tbl[5]  = '{DW'(9), DW'(0), 1'b0, 64'd81};
    tbl[6]  = '{DW'(2), DW'(0), 1'b0, 64'd4};
    tbl[7]  = '{DW'(9), DW'(0), 1'b0, 64'd81};
    tbl[8]  = '{DW'(1), DW'(0), 1'b0, 64'd1};
    tbl[9]  = '{DW'(0), DW'(0), 1'b0, 64'd0};
    tbl[10] = '{DW'(3), DW'(0), 1'b1, 64'd9};

    model_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    data_re  = '0;
    data_im  = '0;
    s_rst_n  = 1'b1;
    #1 s_rst_n = 1'b0;
    #1 check_all_zero();
    idle(2);
    s_rst_n = 1'b1;
    idle(1);

    // Directed table: single bin, extremes, then the reference 8-bin frame.
    for (int k = 0; k < 11; k++) begin
      step(1'b1, tbl[k].last, tbl[k].re, tbl[k].im, tbl[k].mag);
      if (k == 0) idle(3);
      if (k == 2) idle(4);
    end
    idle(2);
    chk("n8 peak_valid", 64'(bus0.peak_valid), 64'd1);
    chk("n8 peak_idx", 64'(bus0.peak_idx), 64'd2);
    chk("n8 peak_mag", 64'(bus0.peak_mag), 64'd81);
    chk("n8 frame_err", 64'(bus0.frame_err), 64'd0);
    idle(2);

    // Back-to-back frames, second frame peaks at bin 0.
    for (int k = 0; k < 8; k++) rnd_bin(k == 7, 50);
    step(1'b1, 1'b0, DW'(8191), DW'(8191), 64'd134184962);
    for (int k = 1; k < 8; k++) rnd_bin(k == 7, 50);
    idle(4);

    // Short frame, then a frame missing in_last, then a short tail frame.
    for (int k = 0; k < 6; k++) rnd_bin(k == 5, 0);
    for (int k = 0; k < 11; k++) rnd_bin(k == 10, 0);
    idle(4);

    // All-zero frame and a lone bin-0 frame.
    for (int k = 0; k < 8; k++) step(1'b1, k == 7, '0, '0, 0);
    step(1'b1, 1'b1, DW'(7), DW'(1), 64'd50);
    idle(4);

    // Randomized stream with gaps and random frame ends.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) rnd_bin($urandom_range(0, 19) == 0, ($urandom_range(0, 3) == 0) ? 20 : 0);
      else idle(1);
    end
    idle(4);

    // Reset in the middle of a frame, then a clean frame.
    for (int k = 0; k < 3; k++) rnd_bin(1'b0, 0);
    async_reset();
    for (int k = 0; k < 8; k++) rnd_bin(k == 7, 100);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
